// File: rtl/stream_cypher_lfsr_pkg.sv
// Shared constants, FSM encoding and the keystream step function for the
// LFSR stream cypher.
package stream_cypher_pkg;

  localparam int          LFSR_W = 32;
  localparam logic [31:0] TAPS   = 32'h8020_0003;
  localparam logic [31:0] SAFE   = 32'h0000_0001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One Galois step: shift right, fold the mask back in when a 1 falls out.
  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s,
    input logic [LFSR_W-1:0] taps = TAPS
  );
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/stream_cypher_lfsr_keystream.sv
// Seeded Galois LFSR. Produces the keystream word for the current state and
// advances one step per accepted data word.
module keystream_lfsr
  import stream_cypher_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter logic [LFSR_W-1:0] TAP_MASK = TAPS,
  parameter logic [LFSR_W-1:0] ZERO_SUB = SAFE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              adv_i,
  output logic [DATA_W-1:0] ks_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // An all-zero state would lock the register, so a zero seed is swapped out.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? ZERO_SUB : seed_i;
    end else if (adv_i) begin
      lfsr_d = lfsr_next(lfsr_q, TAP_MASK);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= ZERO_SUB;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign ks_o = lfsr_q[DATA_W-1:0];

endmodule

// File: rtl/stream_cypher_lfsr.sv
// Pipelined XOR stream cypher: valid/ready input, one-word output register,
// keystream from an internal seeded LFSR. Encrypts and decrypts identically.
module stream_cypher_lfsr
  import stream_cypher_pkg::state_e;
  import stream_cypher_pkg::IDLE;
  import stream_cypher_pkg::RUN;
#(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = 32'h8020_0003,
  parameter logic [LFSR_W-1:0] SAFE   = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              bypass,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       word_cnt,
  output logic              seeded
);

  state_e            state_q;
  logic              seeded_q;
  logic              out_valid_q;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_d;
  logic [31:0]       word_cnt_q;
  logic [31:0]       word_cnt_d;
  logic [DATA_W-1:0] ks;
  logic              accept;

  // A word transfers on a side when valid && ready are both high at a rising
  // edge; valid never waits on ready, and in_ready never looks at in_valid.
  assign in_ready = (state_q == RUN) && !seed_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  keystream_lfsr #(
    .DATA_W   (DATA_W),
    .TAP_MASK (TAPS),
    .ZERO_SUB (SAFE)
  ) u_keystream (
    .clk    (clk),
    .rst    (rst),
    .load_i (seed_load),
    .seed_i (seed),
    .adv_i  (accept),
    .ks_o   (ks)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      seeded_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seed_load) begin
            state_q  <= RUN;
            seeded_q <= 1'b1;
          end
        end
        RUN: begin
          state_q  <= RUN;
          seeded_q <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          seeded_q <= 1'b0;
        end
      endcase
    end
  end

  // Accept overrides pop, so a simultaneous pop and accept leaves no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bypass ? in_data : (in_data ^ ks);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (seed_load) begin
      word_cnt_d = '0;
    end else if (accept) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign word_cnt  = word_cnt_q;
  assign seeded    = seeded_q;

endmodule

// File: tb/tb_stream_cypher_lfsr.sv
// Bench for stream_cypher_lfsr: directed scenarios plus random traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_stream_cypher_lfsr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        bypass = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [31:0] word_cnt;
  logic        seeded;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic        m_run = 1'b0;
  logic [31:0] m_lfsr = 32'h1;
  logic [31:0] m_cnt = '0;
  logic [7:0]  exp_q[$];
  logic [7:0]  cap_q[$];

  stream_cypher_lfsr #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .bypass    (bypass),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .word_cnt  (word_cnt),
    .seeded    (seeded)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model + compare (every negedge) ----------------
  always @(negedge clk) begin
    logic m_ready;
    if (rst) begin
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data", {24'b0, out_data}, 32'd0);
      chk("rst_word_cnt", word_cnt, 32'd0);
      chk("rst_seeded", {31'b0, seeded}, 32'd0);
      m_run  = 1'b0;
      m_lfsr = 32'h1;
      m_cnt  = '0;
      exp_q.delete();
    end else begin
      m_ready = m_run && !seed_load && (exp_q.size() == 0 || out_ready);
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      chk("seeded", {31'b0, seeded}, {31'b0, m_run});
      chk("word_cnt", word_cnt, m_cnt);
      if (exp_q.size() != 0) begin
        chk("out_data", {24'b0, out_data}, {24'b0, exp_q[0]});
        if (out_ready) begin
          cap_q.push_back(out_data);
          void'(exp_q.pop_front());
        end
      end
      if (seed_load) begin
        m_lfsr = (seed == 0) ? 32'h1 : seed;
        m_cnt  = '0;
        m_run  = 1'b1;
      end else if (in_valid && m_ready) begin
        exp_q.push_back(bypass ? in_data : (in_data ^ m_lfsr[7:0]));
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
        m_cnt  = m_cnt + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_load = 1'b1;
    seed      = s;
    cyc();
    seed_load = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic b);
    int   n;
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    bypass   = b;
    n        = 0;
    acc      = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL send_timeout act=not_accepted exp=accepted data=0x%0h", d);
    end
    in_valid = 1'b0;
    bypass   = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  pt[16];
    logic [7:0]  ct[16];
    logic [31:0] s;

    // 1: no seed -> nothing flows
    repeat (3) cyc();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) begin
      @(negedge clk);
      chk("unseeded_in_ready", {31'b0, in_ready}, 32'd0);
      chk("unseeded_seeded", {31'b0, seeded}, 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // 2: known seed, known words
    out_ready = 1'b1;
    load_seed(32'h0000_00A5);
    cap_q.delete();
    send(8'h3C, 1'b0);
    send(8'h00, 1'b0);
    drain();
    chk("t2_count", cap_q.size(), 32'd2);
    chk("t2_word0", {24'b0, cap_q[0]}, 32'h99);
    chk("t2_word1", {24'b0, cap_q[1]}, 32'h51);
    chk("t2_word_cnt", word_cnt, 32'd2);

    // 3: round trip
    s = $urandom;
    load_seed(s);
    cap_q.delete();
    for (int i = 0; i < 16; i++) begin
      pt[i] = 8'($urandom_range(0, 255));
      send(pt[i], 1'b0);
    end
    drain();
    chk("t3_ct_count", cap_q.size(), 32'd16);
    for (int i = 0; i < 16; i++) ct[i] = cap_q[i];
    load_seed(s);
    cap_q.delete();
    for (int i = 0; i < 16; i++) send(ct[i], 1'b0);
    drain();
    chk("t3_pt_count", cap_q.size(), 32'd16);
    for (int i = 0; i < 16; i++) chk("t3_roundtrip", {24'b0, cap_q[i]}, {24'b0, pt[i]});
    chk("t3_word_cnt", word_cnt, 32'd16);

    // 4: backpressure
    load_seed($urandom);
    cap_q.delete();
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h22;
    repeat (5) begin
      @(negedge clk);
      chk("t4_stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("t4_stall_out_valid", {31'b0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    chk("t4_stall_word_cnt", word_cnt, 32'd1);
    out_ready = 1'b1;
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    drain();
    chk("t4_no_loss_dup", cap_q.size(), 32'd3);

    // 5: zero seed and bypass
    load_seed(32'h0);
    cap_q.delete();
    send(8'hFF, 1'b0);
    send(8'h77, 1'b1);
    send(8'h10, 1'b0);
    drain();
    chk("t5_count", cap_q.size(), 32'd3);
    chk("t5_safe_word", {24'b0, cap_q[0]}, 32'hFE);
    chk("t5_bypass_word", {24'b0, cap_q[1]}, 32'h77);
    chk("t5_third_ks", {24'b0, cap_q[2]}, 32'h12);

    // 6: async reset with a held word, then reseed mid-stream
    load_seed($urandom);
    out_ready = 1'b0;
    send(8'h5A, 1'b0);
    #1;
    chk("t6_pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_async_seeded", {31'b0, seeded}, 32'd0);
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA0;
    cyc();
    in_valid = 1'b0;
    load_seed($urandom);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    seed_load = 1'b1;
    seed      = $urandom;
    in_valid  = 1'b1;
    in_data   = 8'h03;
    @(negedge clk);
    chk("t6_reseed_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    chk("t6_reseed_word_cnt", word_cnt, 32'd0);
    send(8'h03, 1'b0);
    drain();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      bypass    = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 49) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cyc();
    end
    seed_load = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
